// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache access controller.
// Contents: the FSM state enum, default address/block widths, and the bit
// positions of the tag, set and offset fields within a CPU address.
package cache_ctrl_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int BLOCK_W_DEF = 256;

  // Address field layout: tag[15:8], set[7:5], byte offset[4:0]
  localparam int TAG_MSB = 15;
  localparam int TAG_LSB = 8;
  localparam int SET_MSB = 7;
  localparam int SET_LSB = 5;
  localparam int OFF_W   = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    HIT_RESP  = 3'd2,
    MEM_REQ   = 3'd3,
    MEM_WAIT  = 3'd4,
    REFILL    = 3'd5,
    MISS_RESP = 3'd6,
    ERR_RESP  = 3'd7
  } state_e;

endpackage

// File: rtl/cache_stat_counter.sv
// Saturating statistics counter.
// Ports: clk, rst_n (sync, active-low), clr (sync clear), inc (count one event),
//        count (current value; holds at all-ones instead of wrapping).
module cache_stat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/cache_access_controller.sv
// Sequencing FSM for a 2-way set-associative read-only cache datapath.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cpuReq/cpuAddr/cpuReady         CPU read request handshake (accept in IDLE)
//   respValid/respErr/respData      one-cycle response (respErr = memory timeout)
//   dpAddress/Miss/outblock         datapath lookup address and its hit/miss result
//   writeLM/writeLRUM/writeTag/
//   writeCWay/dpInblock             datapath update strobes and refill block
//   memReq/memAddr/memValid/memData block fetch handshake with memory
//   hitCount/missCount              saturating statistics
// All control outputs are registered: they are decoded from the next state
// so that they line up with the state they belong to.
module cache_access_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int TMO_CYC = 255,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpuReq,
  input  logic [ADDR_W-1:0]  cpuAddr,
  output logic               cpuReady,
  output logic               respValid,
  output logic               respErr,
  output logic [BLOCK_W-1:0] respData,
  output logic [ADDR_W-1:0]  dpAddress,
  output logic               writeLM,
  output logic               writeLRUM,
  output logic               writeTag,
  output logic               writeCWay,
  output logic [BLOCK_W-1:0] dpInblock,
  input  logic               Miss,
  input  logic [BLOCK_W-1:0] outblock,
  output logic               memReq,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic               memValid,
  input  logic [BLOCK_W-1:0] memData,
  output logic [CNT_W-1:0]   hitCount,
  output logic [CNT_W-1:0]   missCount
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               cpu_ready_q, cpu_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [BLOCK_W-1:0] resp_data_q, resp_data_d;
  logic               mem_req_q, mem_req_d;
  logic               refill_wr_q, refill_wr_d;
  logic               lru_hit_q, lru_hit_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    blk_d   = blk_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (cpuReq) begin
          addr_d  = cpuAddr;
          state_d = LOOKUP;
        end
      end
      LOOKUP:   state_d = Miss ? MEM_REQ : HIT_RESP;
      HIT_RESP: state_d = IDLE;
      MEM_REQ: begin
        tmo_d   = '0;
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // A block arriving on the last allowed cycle still completes the refill.
        if (memValid) begin
          blk_d   = memData;
          state_d = REFILL;
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          state_d = ERR_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      REFILL:    state_d = MISS_RESP;
      MISS_RESP: state_d = IDLE;
      ERR_RESP:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    cpu_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == HIT_RESP) || (state_d == MISS_RESP) || (state_d == ERR_RESP);
    resp_err_d   = (state_d == ERR_RESP);
    mem_req_d    = (state_d == MEM_REQ) || (state_d == MEM_WAIT);
    refill_wr_d  = (state_d == REFILL);
    lru_hit_d    = (state_d == HIT_RESP);
    // Hit data is captured from the datapath at the end of LOOKUP, while
    // dpAddress has been stable for the whole cycle.
    resp_data_d  = '0;
    if (state_d == HIT_RESP)  resp_data_d = outblock;
    if (state_d == MISS_RESP) resp_data_d = blk_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      blk_q        <= '0;
      tmo_q        <= '0;
      cpu_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_req_q    <= 1'b0;
      refill_wr_q  <= 1'b0;
      lru_hit_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      blk_q        <= blk_d;
      tmo_q        <= tmo_d;
      cpu_ready_q  <= cpu_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
      mem_req_q    <= mem_req_d;
      refill_wr_q  <= refill_wr_d;
      lru_hit_q    <= lru_hit_d;
    end
  end

  // A miss is counted at LOOKUP, so timeouts are included in missCount.
  cache_stat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   (state_q == HIT_RESP),
    .count (hitCount)
  );

  cache_stat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .inc   ((state_q == LOOKUP) && Miss),
    .count (missCount)
  );

  assign cpuReady  = cpu_ready_q;
  assign respValid = resp_valid_q;
  assign respErr   = resp_err_q;
  assign respData  = resp_data_q;
  assign dpAddress = addr_q;
  assign memAddr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign memReq    = mem_req_q;
  assign dpInblock = blk_q;
  assign writeTag  = refill_wr_q;
  assign writeCWay = refill_wr_q;
  assign writeLM   = refill_wr_q;
  assign writeLRUM = lru_hit_q;

endmodule

// File: tb/tb_cache_access_controller.sv
// Randomized self-checking bench for cache_access_controller. A behavioural
// datapath (set of installed block addresses) drives Miss/outblock, a
// memory responder answers fetches after a chosen delay, and every
// transaction is checked against its expected timeline, data and counters.
module tb_cache_access_controller;

  localparam int CNT_W = 6;
  localparam int TMO   = 255;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpuReq;
  logic [15:0]  cpuAddr;
  logic         cpuReady, respValid, respErr;
  logic [255:0] respData;
  logic [15:0]  dpAddress, memAddr;
  logic         writeLM, writeLRUM, writeTag, writeCWay;
  logic [255:0] dpInblock, outblock, memData;
  logic         Miss, memReq, memValid;
  logic [CNT_W-1:0] hitCount, missCount;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  exp_hit = 0;
  int  exp_miss = 0;
  bit  installed [2048];

  always #5 clk = ~clk;

  cache_access_controller #(.ADDR_W(16), .BLOCK_W(256), .TMO_CYC(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuReady(cpuReady),
    .respValid(respValid), .respErr(respErr), .respData(respData), .dpAddress(dpAddress),
    .writeLM(writeLM), .writeLRUM(writeLRUM), .writeTag(writeTag), .writeCWay(writeCWay),
    .dpInblock(dpInblock), .Miss(Miss), .outblock(outblock), .memReq(memReq),
    .memAddr(memAddr), .memValid(memValid), .memData(memData),
    .hitCount(hitCount), .missCount(missCount)
  );

  function automatic logic [255:0] hit_pat(input logic [15:0] a);
    return {8{5'b0, a[15:5], 16'hC0DE}};
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  assign Miss     = ~installed[dpAddress[15:5]];
  assign outblock = hit_pat(dpAddress);

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one read at a negedge in IDLE. d<0 means memory never answers.
  task automatic run_req(input logic [15:0] a, input int d, input bit hold);
    bit hit = installed[a[15:5]];
    bit tmo = (d < 0);
    int resp_k, refill_k, mem_hi;
    int bad = 0;
    logic [255:0] md;
    for (int i = 0; i < 8; i++) md[32*i +: 32] = $urandom;
    resp_k   = hit ? 2 : (tmo ? 3 + TMO : 5 + d);
    refill_k = (hit || tmo) ? -1 : 4 + d;
    mem_hi   = tmo ? resp_k - 1 : refill_k - 1;
    if (hit) exp_hit = sat(exp_hit + 1);
    else     exp_miss = sat(exp_miss + 1);
    cpuReq  = 1'b1;
    cpuAddr = a;
    for (int k = 1; k <= resp_k; k++) begin
      @(negedge clk);
      if (cpuReady !== 1'b0) bad++;
      if (dpAddress !== a) bad++;
      if (respValid !== (k == resp_k)) bad++;
      if (writeLRUM !== (hit && k == resp_k)) bad++;
      if (writeTag !== (k == refill_k) || writeCWay !== (k == refill_k) ||
          writeLM !== (k == refill_k)) bad++;
      if (memReq !== (!hit && k >= 2 && k <= mem_hi)) bad++;
      if (k == 2 && !hit) check("memAddr", 256'(memAddr), 256'({a[15:5], 5'b0}));
      if (k == refill_k) check("dpInblock", dpInblock, md);
      if (k == resp_k) begin
        check("respErr", 256'(respErr), 256'(tmo));
        check("respData", respData, hit ? hit_pat(a) : (tmo ? 256'd0 : md));
      end
      memValid = 1'b0;
      memData  = ~md;
      if (!hold || k == resp_k) cpuReq = 1'b0;
      else cpuAddr = 16'($urandom);
      if (!hit && !tmo && k == 3 + d) begin
        memValid = 1'b1;
        memData  = md;
      end else if (k == 1 && $urandom_range(0, 1) == 1) begin
        memValid = 1'b1;
      end
    end
    check("timeline", 256'(bad), 256'd0);
    if (refill_k > 0) installed[a[15:5]] = 1'b1;
    @(negedge clk);
    check("idle_ready", 256'(cpuReady), 256'd1);
    check("idle_resp", 256'(respValid), 256'd0);
    check("hitCount", 256'(hitCount), 256'(exp_hit));
    check("missCount", 256'(missCount), 256'(exp_miss));
  endtask

  // Reset during MEM_WAIT, then a late memValid that must be ignored.
  task automatic reset_mid_op(input logic [15:0] a);
    int bad = 0;
    cpuReq  = 1'b1;
    cpuAddr = a;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cpuReq = 1'b0;
    end
    check("rst_pre_memReq", 256'(memReq), 256'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_memReq", 256'(memReq), 256'd0);
    check("rst_ready", 256'(cpuReady), 256'd1);
    check("rst_hitCount", 256'(hitCount), 256'd0);
    check("rst_missCount", 256'(missCount), 256'd0);
    exp_hit  = 0;
    exp_miss = 0;
    memValid = 1'b1;
    memData  = {8{32'hDEADBEEF}};
    @(negedge clk);
    memValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (respValid !== 1'b0 || writeTag !== 1'b0 || memReq !== 1'b0 || cpuReady !== 1'b1) bad++;
      @(negedge clk);
    end
    check("late_memValid", 256'(bad), 256'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    cpuReq   = 1'b0;
    cpuAddr  = '0;
    memValid = 1'b0;
    memData  = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 256'(cpuReady), 256'd1);
    check("reset_outs", 256'({respValid, respErr, memReq, writeLM, writeLRUM, writeTag, writeCWay}), 256'd0);
    check("reset_data", respData, 256'd0);
    check("reset_addr", 256'({dpAddress, memAddr}), 256'd0);
    check("reset_cnt", 256'({hitCount, missCount}), 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(16'h1234, 2, 1'b0);   // cold miss
    run_req(16'h1234, 0, 1'b0);   // hit
    run_req(16'h2200, -1, 1'b0);  // timeout
    run_req(16'h3300, 4, 1'b1);   // request held while busy
    run_req(16'h1234, 0, 1'b1);   // back-to-back
    run_req(16'h3300, 0, 1'b0);
    run_req(16'h4400, TMO - 1, 1'b0); // memValid on the last allowed cycle

    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 23) << 5) | 16'($urandom_range(0, 31));
      run_req(a, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end
    run_req(16'h2200, -1, 1'b1);

    reset_mid_op(16'hF000);
    check("rst_not_installed", 256'(installed[11'h780]), 256'd0);

    for (int i = 0; i < MAXC + 4; i++) run_req(16'h1234, 0, 1'b0);
    check("hit_saturated", 256'(hitCount), 256'(MAXC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
